// File: rtl/qracc_sram_ctrl.sv
// qracc_sram_ctrl
// Sequences single-row read and write accesses to the QrAcc analog SRAM macro.
// One request is accepted in IDLE. The controller then walks through
// PCH -> WL -> (SENSE for reads) -> DONE and drives precharge, wordline,
// column-select, write and sense-enable timing on the analog bundle.
// Every analog output is a flop, so the macro never sees decode glitches.
//
// Build option: define QRACC_SRAM_SKIP_WR_PCH_EN so that writes go from IDLE
// straight to WL without precharge. Reads always precharge.

module qracc_sram_ctrl #(
    parameter int numRows   = 128,
    parameter int numCols   = 32,
    parameter int pchCycles = 2,
    parameter int wlCycles  = 2,
    parameter int saCycles  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    // digital request/response channel
    input  logic                       rq_wr_i,
    input  logic                       rq_valid_i,
    output logic                       rq_ready_o,
    input  logic [$clog2(numRows)-1:0] addr_i,
    input  logic [numCols-1:0]         wr_data_i,
    output logic                       rd_valid_o,
    output logic [numCols-1:0]         rd_data_o,
    // analog control bundle, SRAM fields
    output logic [numRows-1:0]         wl_o,
    output logic                       pch_o,
    output logic                       write_o,
    output logic [numCols-1:0]         wr_data_o,
    output logic [numCols-1:0]         csel_o,
    output logic                       saen_o,
    input  logic [numCols-1:0]         sa_out_i
);

    localparam int AW = $clog2(numRows);

    // The down-counter must hold the longest phase length.
    localparam int MAX_CYC = (pchCycles > wlCycles) ?
                             ((pchCycles > saCycles) ? pchCycles : saCycles) :
                             ((wlCycles  > saCycles) ? wlCycles  : saCycles);
    localparam int CW = $clog2(MAX_CYC + 1);

    // Each phase loads length-1, so it lasts exactly that many cycles.
    localparam logic [CW-1:0] PCH_LOAD = CW'(pchCycles - 1);
    localparam logic [CW-1:0] WL_LOAD  = CW'(wlCycles - 1);
    localparam logic [CW-1:0] SA_LOAD  = CW'(saCycles - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [numCols-1:0] COLS_ZERO = {numCols{1'b0}};
    localparam logic [numCols-1:0] COLS_ONES = {numCols{1'b1}};
    localparam logic [numRows-1:0] ROWS_ZERO = {numRows{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PCH   = 3'd1,
        ST_WL    = 3'd2,
        ST_SENSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic                 wr_r;
    logic [AW-1:0]        addr_r;
    logic [numCols-1:0]   data_r;

    // Row decoder. An address with no matching row (possible only when
    // numRows is not a power of two) leaves every wordline low.
    function automatic logic [numRows-1:0] row_decode(input logic [AW-1:0] a);
        logic [numRows-1:0] oh;
        oh = ROWS_ZERO;
        for (int i = 0; i < numRows; i++) begin
            oh[i] = (a == AW'(i));
        end
        return oh;
    endfunction

    // Access sequencer: state, phase counter, latched request and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            wr_r       <= 1'b0;
            addr_r     <= {AW{1'b0}};
            data_r     <= COLS_ZERO;
            rq_ready_o <= 1'b1;
            rd_valid_o <= 1'b0;
            rd_data_o  <= COLS_ZERO;
            wl_o       <= ROWS_ZERO;
            pch_o      <= 1'b0;
            write_o    <= 1'b0;
            wr_data_o  <= COLS_ZERO;
            csel_o     <= COLS_ZERO;
            saen_o     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rd_valid_o <= 1'b0;
                    if (rq_valid_i) begin
                        // Handshake: ready is high throughout IDLE.
                        wr_r       <= rq_wr_i;
                        addr_r     <= addr_i;
                        data_r     <= wr_data_i;
                        rq_ready_o <= 1'b0;
`ifdef QRACC_SRAM_SKIP_WR_PCH_EN
                        if (rq_wr_i) begin
                            // Writes overdrive the bitlines, so precharge is skipped.
                            state_r   <= ST_WL;
                            cnt_r     <= WL_LOAD;
                            wl_o      <= row_decode(addr_i);
                            csel_o    <= COLS_ONES;
                            write_o   <= 1'b1;
                            wr_data_o <= wr_data_i;
                        end else begin
                            state_r <= ST_PCH;
                            cnt_r   <= PCH_LOAD;
                            pch_o   <= 1'b1;
                        end
`else
                        state_r <= ST_PCH;
                        cnt_r   <= PCH_LOAD;
                        pch_o   <= 1'b1;
`endif
                    end else begin
                        rq_ready_o <= 1'b1;
                    end
                end

                ST_PCH: begin
                    if (cnt_r == CNT_ZERO) begin
                        // Precharge ends in the same edge the wordline rises,
                        // so PCH and WL never overlap.
                        state_r   <= ST_WL;
                        cnt_r     <= WL_LOAD;
                        pch_o     <= 1'b0;
                        wl_o      <= row_decode(addr_r);
                        csel_o    <= COLS_ONES;
                        write_o   <= wr_r;
                        wr_data_o <= wr_r ? data_r : COLS_ZERO;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end

                ST_WL: begin
                    if (cnt_r == CNT_ZERO) begin
                        if (wr_r) begin
                            state_r   <= ST_DONE;
                            cnt_r     <= CNT_ZERO;
                            wl_o      <= ROWS_ZERO;
                            csel_o    <= COLS_ZERO;
                            write_o   <= 1'b0;
                            wr_data_o <= COLS_ZERO;
                        end else begin
                            // Wordline and column select stay up while sensing.
                            state_r <= ST_SENSE;
                            cnt_r   <= SA_LOAD;
                            saen_o  <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end

                ST_SENSE: begin
                    if (cnt_r == CNT_ZERO) begin
                        // Capture the sense amps on the last sensing edge.
                        state_r    <= ST_DONE;
                        rd_data_o  <= sa_out_i;
                        rd_valid_o <= 1'b1;
                        saen_o     <= 1'b0;
                        wl_o       <= ROWS_ZERO;
                        csel_o     <= COLS_ZERO;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end

                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= CNT_ZERO;
                    rd_valid_o <= 1'b0;
                    rq_ready_o <= 1'b1;
                end

                default: begin
                    // Unreachable encoding: park safely with the macro idle.
                    state_r    <= ST_IDLE;
                    cnt_r      <= CNT_ZERO;
                    rq_ready_o <= 1'b1;
                    rd_valid_o <= 1'b0;
                    wl_o       <= ROWS_ZERO;
                    pch_o      <= 1'b0;
                    write_o    <= 1'b0;
                    wr_data_o  <= COLS_ZERO;
                    csel_o     <= COLS_ZERO;
                    saen_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qracc_sram_ctrl.sv
// Testbench for qracc_sram_ctrl: randomized requests against a transaction-level
// reference (memory array plus a per-access phase timeline), a behavioural
// macro model that stores writes and answers sense-amp reads, and a scoreboard
// queue of expected read responses.

module tb_qracc_sram_ctrl;

    localparam int ROWS = 128;
    localparam int COLS = 32;
    localparam int AW   = 7;
    localparam int PCH  = 2;
    localparam int WLC  = 2;
    localparam int SAC  = 1;
`ifdef QRACC_SRAM_SKIP_WR_PCH_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              rq_wr, rq_valid, rq_ready;
    logic [AW-1:0]     addr;
    logic [COLS-1:0]   wr_data, rd_data, wr_data_bl, csel, sa_out;
    logic              rd_valid, pch, write_en, saen;
    logic [ROWS-1:0]   wl;

    // second instance with non-default timing
    logic              rq_wr2, rq_valid2, rq_ready2, rd_valid2, pch2, write2, saen2;
    logic [AW-1:0]     addr2;
    logic [COLS-1:0]   wr_data2, rd_data2, wdo2, csel2, sa_out2;
    logic [ROWS-1:0]   wl2;

    qracc_sram_ctrl #(.numRows(ROWS), .numCols(COLS), .pchCycles(PCH),
                      .wlCycles(WLC), .saCycles(SAC)) u_dut (
        .clk(clk), .rst(rst),
        .rq_wr_i(rq_wr), .rq_valid_i(rq_valid), .rq_ready_o(rq_ready),
        .addr_i(addr), .wr_data_i(wr_data),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .wl_o(wl), .pch_o(pch), .write_o(write_en), .wr_data_o(wr_data_bl),
        .csel_o(csel), .saen_o(saen), .sa_out_i(sa_out)
    );

    qracc_sram_ctrl #(.numRows(ROWS), .numCols(COLS), .pchCycles(3),
                      .wlCycles(1), .saCycles(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .rq_wr_i(rq_wr2), .rq_valid_i(rq_valid2), .rq_ready_o(rq_ready2),
        .addr_i(addr2), .wr_data_i(wr_data2),
        .rd_valid_o(rd_valid2), .rd_data_o(rd_data2),
        .wl_o(wl2), .pch_o(pch2), .write_o(write2), .wr_data_o(wdo2),
        .csel_o(csel2), .saen_o(saen2), .sa_out_i(sa_out2)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    function automatic logic [COLS-1:0] seed_val(input int i);
        logic [31:0] t;
        t = 32'(i);
        return (t * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic int onehot_idx(input logic [ROWS-1:0] v);
        int idx = -1;
        int cnt = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (v[i]) begin
                idx = i;
                cnt++;
            end
        end
        return (cnt == 1) ? idx : -1;
    endfunction

    function automatic logic [ROWS-1:0] onehot(input logic [AW-1:0] a);
        logic [ROWS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural analog macro ----------------
    logic [COLS-1:0] macro_mem [ROWS];
    logic [COLS-1:0] junk = '0;
    bit              mm_init = 1'b0;
    int              sa_row;

    always @(negedge clk) junk <= $urandom;

    always @(posedge clk) begin
        if (!mm_init) begin
            for (int i = 0; i < ROWS; i++) macro_mem[i] <= seed_val(i);
            mm_init <= 1'b1;
        end else if (write_en && onehot_idx(wl) >= 0) begin
            macro_mem[onehot_idx(wl)] <= wr_data_bl;
        end
    end

    always_comb begin
        sa_row = onehot_idx(wl);
        if (saen && sa_row >= 0) sa_out = macro_mem[sa_row];
        else                     sa_out = junk;
    end

    assign sa_out2 = saen2 ? 32'h1234_5678 : junk;

    // ---------------- reference model ----------------
    typedef struct { logic [COLS-1:0] data; int at; } exp_t;
    exp_t            sbq[$];
    logic [COLS-1:0] ref_mem [ROWS];
    int              edge_cnt = 0;
    int              acc_cnt  = 0;
    bit              act      = 1'b0;
    int              e0 = 0, done_e = 0, p_eff = 0;
    bit              a_wr = 1'b0;
    logic [AW-1:0]   a_addr = '0;
    logic [COLS-1:0] a_data = '0;
    logic [COLS-1:0] last_rd = '0;

    // Decides acceptance from the model's own notion of busy, and records
    // the accepted transaction and its expected phase timeline.
    initial begin
        for (int i = 0; i < ROWS; i++) ref_mem[i] = seed_val(i);
        forever begin
            @(posedge clk);
            if (rst) begin
                act     = 1'b0;
                sbq.delete();
                last_rd = '0;
            end else begin
                if (act && !a_wr && edge_cnt == done_e - 1) last_rd = a_data;
                if (act && edge_cnt > done_e) act = 1'b0;
                if (!act && rq_valid) begin
                    a_wr   = rq_wr;
                    a_addr = addr;
                    p_eff  = (rq_wr && SKIP) ? 0 : PCH;
                    a_data = rq_wr ? wr_data : ref_mem[addr];
                    if (rq_wr) ref_mem[addr] = wr_data;
                    e0     = edge_cnt;
                    done_e = edge_cnt + p_eff + WLC + (rq_wr ? 0 : SAC) + 1;
                    act    = 1'b1;
                    acc_cnt++;
                    if (!rq_wr) sbq.push_back('{a_data, e0 + PCH + WLC + SAC + 1});
                end
            end
            edge_cnt++;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t            e;
        int              k, hi;
        bit              busy;
        logic            e_ready, e_pch, e_write, e_saen;
        logic [ROWS-1:0] e_wl;
        logic [COLS-1:0] e_csel, e_wdo;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rd_valid) begin
                    n_checks++;
                    if (sbq.size() == 0) begin
                        n_errors++;
                        $display("FAIL rd_valid_unexpected: got pulse at edge %0d expected none", edge_cnt);
                    end else begin
                        e = sbq.pop_front();
                        if (rd_data !== e.data || edge_cnt != e.at) begin
                            n_errors++;
                            $display("FAIL read_response: got data %h at edge %0d expected %h at edge %0d",
                                     rd_data, edge_cnt, e.data, e.at);
                        end
                    end
                end
                if (sbq.size() > 0 && edge_cnt > sbq[0].at) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rd_valid_missing: got none expected pulse at edge %0d", sbq[0].at);
                    void'(sbq.pop_front());
                end

                busy    = act && (edge_cnt <= done_e);
                k       = edge_cnt - e0;
                hi      = p_eff + WLC + (a_wr ? 0 : SAC);
                e_ready = !busy;
                e_pch   = busy && k >= 1 && k <= p_eff;
                e_wl    = (busy && k > p_eff && k <= hi) ? onehot(a_addr) : '0;
                e_csel  = (busy && k > p_eff && k <= hi) ? '1 : '0;
                e_write = busy && a_wr && k > p_eff && k <= p_eff + WLC;
                e_wdo   = e_write ? a_data : '0;
                e_saen  = busy && !a_wr && k > p_eff + WLC && k <= hi;
                n_checks++;
                if (rq_ready !== e_ready || pch !== e_pch || wl !== e_wl || csel !== e_csel ||
                    write_en !== e_write || wr_data_bl !== e_wdo || saen !== e_saen ||
                    rd_data !== last_rd) begin
                    n_errors++;
                    $display("FAIL cycle_outputs edge %0d: got rdy=%b pch=%b wr=%b sa=%b wl=%h csel=%h wdo=%h rdd=%h expected rdy=%b pch=%b wr=%b sa=%b wl=%h csel=%h wdo=%h rdd=%h",
                             edge_cnt, rq_ready, pch, write_en, saen, wl, csel, wr_data_bl, rd_data,
                             e_ready, e_pch, e_write, e_saen, e_wl, e_csel, e_wdo, last_rd);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic scramble_fields();
        rq_wr   = 1'($urandom_range(0, 1));
        addr    = AW'($urandom_range(0, ROWS - 1));
        wr_data = $urandom;
    endtask

    // Call #1 after a posedge; returns #1 after the accepting edge.
    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [COLS-1:0] d, input bit scr);
        int start;
        int n;
        start    = acc_cnt;
        n        = 0;
        rq_wr    = wr;
        addr     = a;
        wr_data  = d;
        rq_valid = 1'b1;
        while (acc_cnt == start && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (acc_cnt == start && scr) scramble_fields();
        end
        if (acc_cnt == start) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got no acceptance expected one within 60 cycles");
        end
        rq_valid = 1'b0;
        scramble_fields();
    endtask

    initial begin
        int lat;
        int sa_cnt;
        bit bad;
        logic [COLS-1:0] got2;
        rst = 1'b1; rq_valid = 1'b0; rq_wr = 1'b0; addr = '0; wr_data = '0;
        rq_valid2 = 1'b0; rq_wr2 = 1'b0; addr2 = '0; wr_data2 = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready",    {127'd0, rq_ready}, 128'd1);
        chk("reset_rd_valid", {127'd0, rd_valid}, 128'd0);
        chk("reset_wl",       wl,                 128'd0);
        chk("reset_pch",      {127'd0, pch},      128'd0);
        chk("reset_saen",     {127'd0, saen},     128'd0);
        chk("reset_rd_data",  {96'd0, rd_data},   128'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        // directed write/read of row 5, then a busy-held read followed by a write
        issue(1'b1, 7'd5, 32'hA5A5_0F0F, 1'b0);
        issue(1'b0, 7'd5, 32'h0, 1'b0);
        issue(1'b0, 7'd9, 32'h0, 1'b1);
        issue(1'b1, 7'd9, 32'hDEAD_BEEF, 1'b1);
        repeat (8) @(posedge clk);
        #1;

        // reset while a read sits in WL, then a fresh read
        issue(1'b0, 7'd5, 32'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        issue(1'b0, 7'd5, 32'h0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            issue(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, ROWS - 1)) : AW'($urandom_range(0, 11)),
                  $urandom, 1'($urandom_range(0, 1)));
        end
        repeat (12) @(posedge clk);
        #1;

        // non-default timing instance: pch=3, wl=1, sa=2
        addr2     = 7'd3;
        rq_valid2 = 1'b1;
        @(posedge clk);
        #1 rq_valid2 = 1'b0;
        lat = 0; sa_cnt = 0; bad = 1'b0; got2 = '0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (saen2) begin
                sa_cnt++;
                if (wl2 == '0 || write2 || csel2 != '1) bad = 1'b1;
            end
            if (pch2 && (wl2 != '0 || write2)) bad = 1'b1;
            if (wdo2 != '0) bad = 1'b1;
            if (rd_valid2) begin
                got2 = rd_data2;
                break;
            end
        end
        chk("p2_read_latency", 128'(lat - 1), 128'd6);
        chk("p2_saen_cycles",  128'(sa_cnt),  128'd2);
        chk("p2_rd_data",      {96'd0, got2}, {96'd0, 32'h1234_5678});
        chk("p2_phase_rules",  {127'd0, bad}, 128'd0);
        repeat (2) @(negedge clk);
        chk("p2_ready_back",   {127'd0, rq_ready2}, 128'd1);

        chk("scoreboard_drained", 128'(sbq.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/qracc_sram_ctrl.md
# qracc_sram_ctrl

- Sequences single-row read and write accesses to the QrAcc analog SRAM macro.
- Accepts requests on the digital SRAM request/response channel (ready/valid request, pulsed read-valid response).
- Generates precharge, wordline, write and sense-amp timing on the SRAM fields of the analog control bundle, and captures sense-amp output.
- Sits between the top-level SRAM master (weight loader / host) and the analog macro.

## Interface
- `numRows`, 128: macro rows; address width `$clog2(numRows)`.
- `numCols`, 32: macro columns / data width.
- `pchCycles`, 2: precharge duration in cycles, ≥1.
- `wlCycles`, 2: wordline-only duration in cycles, ≥1.
- `saCycles`, 1: sense-enable duration in cycles, ≥1.

Ports:
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `rq_wr_i` in 1: 1 = write, 0 = read.
- `rq_valid_i` in 1: request valid.
- `rq_ready_o` out 1: request taken on the edge where `rq_valid_i && rq_ready_o`.
- `addr_i` in `$clog2(numRows)`: row address.
- `wr_data_i` in `numCols`: write data.
- `rd_valid_o` out 1: one-cycle pulse; `rd_data_o` is valid in that cycle.
- `rd_data_o` out `numCols`: last read result.
- `wl_o` out `numRows`: one-hot wordline (WL).
- `pch_o` out 1: bitline precharge, active-high (PCH).
- `write_o` out 1: write drivers enable (WRITE).
- `wr_data_o` out `numCols`: bitline write data (WR_DATA).
- `csel_o` out `numCols`: column select (CSEL).
- `saen_o` out 1: sense-amp enable (SAEN).
- `sa_out_i` in `numCols`: sense-amp outputs (SA_OUT).

## Operation
- FSM states: IDLE, PCH, WL, SENSE, DONE.
- One down-counter, width `$clog2(max(pchCycles,wlCycles,saCycles)+1)`, is loaded on each state entry.
- **IDLE**
  - `rq_ready_o=1`; all analog outputs 0.
  - On handshake, latch `rq_wr_i`, `addr_i` and `wr_data_i`, then go to PCH.
- **PCH**
  - `pch_o=1` for `pchCycles` cycles, then go to WL.
- **WL**
  - `wl_o[addr]=1`, `csel_o` all ones, for `wlCycles` cycles.
  - Write: `write_o=1` and `wr_data_o`=latched data; then go to DONE.
  - Read: `write_o=0` and `wr_data_o=0`; then go to SENSE.
- **SENSE** (reads only)
  - `wl_o` and `csel_o` stay asserted; `saen_o=1` for `saCycles` cycles.
  - On the last SENSE edge, `sa_out_i` is registered into `rd_data_o`; then go to DONE.
- **DONE**
  - One cycle; `rd_valid_o=1` for reads, 0 for writes. Then go to IDLE.
- `rq_ready_o` is 1 only in IDLE.
  - `rq_valid_i` in any other state is ignored and is not queued.
  - Input changes after acceptance have no effect.
- `rd_data_o` holds its value until the next read completes; writes never change it.
- If `addr_i ≥ numRows` (non-power-of-two `numRows`), `wl_o` stays all-zero; the FSM still runs and the read returns whatever `sa_out_i` shows.
- All analog outputs are registered, so they are glitch-free.

## Timing
- Reset (`rst=1` at an edge): state IDLE, counter 0.
  - All outputs 0 except `rq_ready_o=1`.
  - `rd_data_o=0`.
- Reset mid-access aborts it: no `rd_valid_o`, and all analog outputs drop after that edge.
- Read accepted at edge E0, with defaults:
  - PCH during E0–E2, WL during E2–E4, SENSE during E4–E5.
  - `rd_valid_o` high during E5–E6.
  - `rq_ready_o` high again after E6; the next acceptance is at E7 at the earliest.
- General read latency: acceptance to `rd_valid_o` = `pchCycles+wlCycles+saCycles` edges.
- Write latency: acceptance to IDLE = `pchCycles+wlCycles+1` edges.
  - With defaults, the write occupies 5 cycles and the next acceptance is at E6 at the earliest.
- Back-to-back requests: at most one outstanding; no overlap between accesses.
- `pch_o`, `wl_o` and `write_o` are never high in the same cycle as `pch_o`.
- `saen_o` is high only while `wl_o` is non-zero and `write_o=0`.

## Configuration
- `QRACC_SRAM_SKIP_WR_PCH_EN`
  - **Defined:** writes go IDLE→WL directly, skipping PCH. Write latency is `wlCycles+1`. Reads are unchanged.
  - **Undefined:** writes precharge like reads, as described above.

## Test plan
- **Reset then idle:** hold `rst` 3 cycles → `rq_ready_o=1`, `rd_valid_o=0`, `wl_o=0`, `pch_o=0`, `saen_o=0`, `rd_data_o=0`.
- **Write then read, defaults:**
  - Write `addr=5`, `data=32'hA5A5_0F0F` → `pch_o` high 2 cycles, then `wl_o=1<<5` with `write_o=1` and `wr_data_o=A5A5_0F0F` for 2 cycles.
  - Read `addr=5`, with the bench model returning `sa_out_i=A5A5_0F0F` during SENSE → `rd_valid_o` pulses exactly 5 edges after acceptance, and `rd_data_o=A5A5_0F0F`.
- **Busy-ignore:** hold `rq_valid_i=1` with changing `addr` during a read → only the first request is accepted; ready stays low through DONE; the second is taken 2 edges after `rd_valid_o`.
- **Reset mid-access:** assert `rst` during WL of a read → no `rd_valid_o`; all analog outputs 0 the next cycle; a fresh read then completes normally.
- **Parameters:** run `pchCycles=3`, `wlCycles=1`, `saCycles=2` → read latency 6 edges; `saen_o` high exactly 2 cycles.
- **Macro:** with `QRACC_SRAM_SKIP_WR_PCH_EN` defined, a write → `pch_o` never asserts; `wl_o` rises 1 cycle after acceptance; ready returns after 3 edges.
